// File: rtl/sensor_scheduler.sv
// sensor_scheduler: accepts one command at a time, pulses the addressed sensor
// interface, waits for its done pulse (or a timeout) and returns one response.
//
// Handshakes: a command moves when i_cmd_valid && o_cmd_ready on a rising
// edge; a response moves when o_rsp_valid && i_rsp_ready on a rising edge.
// Once o_rsp_valid is raised, status/data stay stable until that edge.
module sensor_scheduler #(
  parameter int NUM_IF         = 8,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst,
  input  logic                  i_cmd_valid,
  input  logic [7:0]            i_cmd_addr,
  input  logic [7:0]            i_cmd_req,
  output logic                  o_cmd_ready,
  output logic [NUM_IF-1:0]     o_if_en,
  output logic [7:0]            o_if_request,
  input  logic [8*NUM_IF-1:0]   i_if_data,
  input  logic [NUM_IF-1:0]     i_if_done,
  output logic                  o_rsp_valid,
  output logic [7:0]            o_rsp_status,
  output logic [7:0]            o_rsp_data,
  input  logic                  i_rsp_ready,
  output logic                  o_busy,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_ENABLE  = 3'd2,
    S_WAIT    = 3'd3,
    S_RESPOND = 3'd4
  } state_t;

  localparam logic [7:0]  ST_OK      = 8'h00;
  localparam logic [7:0]  ST_BAD_IF  = 8'hE1;
  localparam logic [7:0]  ST_BAD_REQ = 8'hE2;
  localparam logic [7:0]  ST_TIMEOUT = 8'hE3;
  localparam logic [7:0]  ST_SENSOR  = 8'hE4;
  // Last counter value still inside the wait window; reaching it means the
  // TIMEOUT_CYCLES-th WAIT cycle is in progress.
  localparam logic [31:0] TO_LIMIT   = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t              state_q, state_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          req_q, req_d;
  logic [31:0]         count_q, count_d;
  logic [NUM_IF-1:0]   if_en_q, if_en_d;
  logic [7:0]          if_req_q, if_req_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rsp_status_q, rsp_status_d;
  logic [7:0]          rsp_data_q, rsp_data_d;

  logic [NUM_IF-1:0]   sel_onehot;
  logic [7:0]          sel_data;
  logic                sel_done;
  logic                addr_ok;
  logic                req_ok;

  // Decode the latched address into a one-hot select and mux its data/done.
  always_comb begin
    sel_onehot = '0;
    sel_data   = 8'h00;
    for (int k = 0; k < NUM_IF; k++) begin
      if (addr_q == 8'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_data      = i_if_data[8*k +: 8];
      end
    end
    sel_done = |(i_if_done & sel_onehot);
    addr_ok  = (32'(addr_q) < 32'(NUM_IF));
    req_ok   = (req_q == 8'h01) || (req_q == 8'h02) || (req_q == 8'h03);
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    req_d        = req_q;
    count_d      = count_q;
    if_en_d      = '0;
    if_req_d     = if_req_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          addr_d  = i_cmd_addr;
          req_d   = i_cmd_req;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!addr_ok) begin
          rsp_status_d = ST_BAD_IF;
          rsp_data_d   = 8'h00;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESPOND;
        end else if (!req_ok) begin
          rsp_status_d = ST_BAD_REQ;
          rsp_data_d   = 8'h00;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESPOND;
        end else begin
          if_en_d  = sel_onehot;
          if_req_d = req_q;
          state_d  = S_ENABLE;
        end
      end
      S_ENABLE: begin
        count_d = 32'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done wins over a timeout landing in the same cycle.
        if (sel_done) begin
          rsp_data_d   = sel_data;
          rsp_status_d = (sel_data == 8'h80) ? ST_SENSOR : ST_OK;
          rsp_valid_d  = 1'b1;
          if_req_d     = 8'h00;
          state_d      = S_RESPOND;
        end else if (count_q >= TO_LIMIT) begin
          rsp_data_d   = 8'h00;
          rsp_status_d = ST_TIMEOUT;
          rsp_valid_d  = 1'b1;
          if_req_d     = 8'h00;
          state_d      = S_RESPOND;
        end else if (count_q != 32'hFFFF_FFFF) begin
          count_d = count_q + 32'd1;
        end
      end
      S_RESPOND: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 8'h00;
      req_q        <= 8'h00;
      count_q      <= 32'd0;
      if_en_q      <= '0;
      if_req_q     <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 8'h00;
      rsp_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      count_q      <= count_d;
      if_en_q      <= if_en_d;
      if_req_q     <= if_req_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Output mapping; ready/busy derive directly from the state register.
  always_comb begin
    o_cmd_ready  = (state_q == S_IDLE);
    o_busy       = (state_q != S_IDLE);
    o_if_en      = if_en_q;
    o_if_request = if_req_q;
    o_rsp_valid  = rsp_valid_q;
    o_rsp_status = rsp_status_q;
    o_rsp_data   = rsp_data_q;
    o_dbg_state  = state_q;
  end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Directed testbench for sensor_scheduler (NUM_IF=8, TIMEOUT_CYCLES=50).
module tb_sensor_scheduler;

  localparam int NUM_IF = 8;
  localparam int TO     = 50;

  logic                i_Clock = 1'b0;
  logic                i_Rst = 1'b1;
  logic                i_cmd_valid = 1'b0;
  logic [7:0]          i_cmd_addr = 8'h00;
  logic [7:0]          i_cmd_req = 8'h00;
  logic                o_cmd_ready;
  logic [NUM_IF-1:0]   o_if_en;
  logic [7:0]          o_if_request;
  logic [8*NUM_IF-1:0] i_if_data = '0;
  logic [NUM_IF-1:0]   i_if_done = '0;
  logic                o_rsp_valid;
  logic [7:0]          o_rsp_status;
  logic [7:0]          o_rsp_data;
  logic                i_rsp_ready = 1'b0;
  logic                o_busy;
  logic [2:0]          o_dbg_state;

  int n_checks = 0;
  int n_fails  = 0;
  int en_cnt[NUM_IF];

  sensor_scheduler #(.NUM_IF(NUM_IF), .TIMEOUT_CYCLES(TO)) dut (
    .i_Clock(i_Clock), .i_Rst(i_Rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_addr(i_cmd_addr), .i_cmd_req(i_cmd_req),
    .o_cmd_ready(o_cmd_ready),
    .o_if_en(o_if_en), .o_if_request(o_if_request),
    .i_if_data(i_if_data), .i_if_done(i_if_done),
    .o_rsp_valid(o_rsp_valid), .o_rsp_status(o_rsp_status), .o_rsp_data(o_rsp_data),
    .i_rsp_ready(i_rsp_ready), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // Clock: 50 MHz.
  always #10 i_Clock = ~i_Clock;

  // Count every enable pulse seen per interface.
  initial for (int k = 0; k < NUM_IF; k++) en_cnt[k] = 0;
  always @(posedge i_Clock) begin
    for (int k = 0; k < NUM_IF; k++) if (o_if_en[k] === 1'b1) en_cnt[k]++;
  end

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int en_total();
    int s = 0;
    for (int k = 0; k < NUM_IF; k++) s += en_cnt[k];
    return s;
  endfunction

  // Present a command in IDLE; returns one cycle after acceptance (DECODE).
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] r);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = a;
    i_cmd_req   = r;
    check("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(o_rsp_valid), 32'd0);
    check("back_idle", 32'(o_dbg_state), 32'd0);
  endtask

  task automatic set_done(input int k, input logic [7:0] d);
    i_if_data[8*k +: 8] = d;
    i_if_done[k] = 1'b1;
  endtask

  initial begin
    // Reset state
    step();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_status", 32'(o_rsp_status), 32'h00);
    check("rst_data", 32'(o_rsp_data), 32'h00);
    check("rst_if_en", 32'(o_if_en), 32'h00);
    check("rst_if_req", 32'(o_if_request), 32'h00);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    i_Rst = 1'b0;
    step();

    // addr 2, temperature, done 10 cycles after the enable with 0x19
    send_cmd(8'd2, 8'h02);
    check("t1_busy", 32'(o_busy), 32'd1);
    check("t1_ready_busy", 32'(o_cmd_ready), 32'd0);
    step();
    check("t1_if_en", 32'(o_if_en), 32'h04);
    check("t1_if_req_en", 32'(o_if_request), 32'h02);
    step();
    check("t1_if_en_off", 32'(o_if_en), 32'h00);
    repeat (9) step();
    check("t1_if_req_wait", 32'(o_if_request), 32'h02);
    check("t1_no_rsp_yet", 32'(o_rsp_valid), 32'd0);
    set_done(2, 8'h19);
    step();
    i_if_done = '0;
    check("t1_valid", 32'(o_rsp_valid), 32'd1);
    check("t1_status", 32'(o_rsp_status), 32'h00);
    check("t1_data", 32'(o_rsp_data), 32'h19);
    check("t1_if_req_clr", 32'(o_if_request), 32'h00);
    check("t1_en_once", 32'(en_cnt[2]), 32'd1);
    finish_rsp();

    // addr 9 -> bad interface, valid 2 cycles after accept
    send_cmd(8'd9, 8'h02);
    check("t2_not_yet", 32'(o_rsp_valid), 32'd0);
    step();
    check("t2_valid", 32'(o_rsp_valid), 32'd1);
    check("t2_status", 32'(o_rsp_status), 32'hE1);
    check("t2_data", 32'(o_rsp_data), 32'h00);
    finish_rsp();
    // addr 8 boundary, and bad addr wins over bad req
    send_cmd(8'd8, 8'h01);
    step();
    check("t2_addr8", 32'(o_rsp_status), 32'hE1);
    finish_rsp();
    send_cmd(8'd9, 8'h07);
    step();
    check("t2_priority", 32'(o_rsp_status), 32'hE1);
    finish_rsp();
    // req 0x07 -> bad request
    send_cmd(8'd1, 8'h07);
    step();
    check("t2_badreq_valid", 32'(o_rsp_valid), 32'd1);
    check("t2_badreq", 32'(o_rsp_status), 32'hE2);
    check("t2_badreq_data", 32'(o_rsp_data), 32'h00);
    finish_rsp();
    check("t2_no_enables", 32'(en_total()), 32'd1);

    // addr 7 (top interface), humidity, done in the first WAIT cycle
    send_cmd(8'd7, 8'h03);
    step();
    step();
    check("t3_wait_novalid", 32'(o_rsp_valid), 32'd0);
    set_done(7, 8'hA5);
    step();
    i_if_done = '0;
    check("t3_valid", 32'(o_rsp_valid), 32'd1);
    check("t3_status", 32'(o_rsp_status), 32'h00);
    check("t3_data", 32'(o_rsp_data), 32'hA5);
    finish_rsp();

    // timeout after 50 WAIT cycles, late done ignored
    send_cmd(8'd4, 8'h03);
    step();
    step();
    repeat (TO - 1) step();
    check("t4_last_wait_state", 32'(o_dbg_state), 32'd3);
    check("t4_last_wait_novalid", 32'(o_rsp_valid), 32'd0);
    step();
    check("t4_valid", 32'(o_rsp_valid), 32'd1);
    check("t4_status", 32'(o_rsp_status), 32'hE3);
    check("t4_data", 32'(o_rsp_data), 32'h00);
    set_done(4, 8'h55);
    step();
    i_if_done = '0;
    check("t4_late_status", 32'(o_rsp_status), 32'hE3);
    check("t4_late_data", 32'(o_rsp_data), 32'h00);
    finish_rsp();
    set_done(4, 8'h55);
    step();
    i_if_done = '0;
    check("t4_idle_done_state", 32'(o_dbg_state), 32'd0);
    check("t4_idle_done_valid", 32'(o_rsp_valid), 32'd0);

    // done on the final WAIT cycle resolves as done
    send_cmd(8'd5, 8'h01);
    step();
    step();
    repeat (TO - 1) step();
    set_done(5, 8'h33);
    step();
    i_if_done = '0;
    check("t5_valid", 32'(o_rsp_valid), 32'd1);
    check("t5_status", 32'(o_rsp_status), 32'h00);
    check("t5_data", 32'(o_rsp_data), 32'h33);
    finish_rsp();

    // sensor error 0x80, backpressure for 20 cycles, early done ignored
    send_cmd(8'd6, 8'h01);
    set_done(6, 8'h44);
    step();
    i_if_done = '0;
    step();
    set_done(6, 8'h80);
    step();
    i_if_done = '0;
    check("t6_status", 32'(o_rsp_status), 32'hE4);
    check("t6_data", 32'(o_rsp_data), 32'h80);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = 8'd2;
    i_cmd_req   = 8'h01;
    for (int i = 0; i < 20; i++) begin
      step();
      check("t6_hold_valid", 32'(o_rsp_valid), 32'd1);
      check("t6_hold_status", 32'(o_rsp_status), 32'hE4);
      check("t6_hold_data", 32'(o_rsp_data), 32'h80);
      check("t6_hold_ready", 32'(o_cmd_ready), 32'd0);
    end
    i_cmd_valid = 1'b0;
    finish_rsp();
    check("t6_no_extra_en", 32'(en_cnt[2]), 32'd1);

    // foreign done ignored, then reset in WAIT aborts
    send_cmd(8'd1, 8'h02);
    step();
    step();
    set_done(3, 8'h77);
    step();
    i_if_done = '0;
    check("t7_foreign_valid", 32'(o_rsp_valid), 32'd0);
    check("t7_foreign_state", 32'(o_dbg_state), 32'd3);
    check("t7_if_req", 32'(o_if_request), 32'h02);
    step();
    i_Rst = 1'b1;
    #1;
    check("t7_rst_state", 32'(o_dbg_state), 32'd0);
    check("t7_rst_busy", 32'(o_busy), 32'd0);
    check("t7_rst_if_req", 32'(o_if_request), 32'h00);
    check("t7_rst_if_en", 32'(o_if_en), 32'h00);
    check("t7_rst_valid", 32'(o_rsp_valid), 32'd0);
    check("t7_rst_status", 32'(o_rsp_status), 32'h00);
    check("t7_rst_data", 32'(o_rsp_data), 32'h00);
    step();
    i_Rst = 1'b0;
    set_done(1, 8'h11);
    step();
    i_if_done = '0;
    step();
    check("t7_post_valid", 32'(o_rsp_valid), 32'd0);
    check("t7_post_state", 32'(o_dbg_state), 32'd0);
    check("t7_post_data", 32'(o_rsp_data), 32'h00);
    check("t7_en_total", 32'(en_total()), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sensor_scheduler.md
SENSOR_SCHEDULER -- requirements
Module: sensor_scheduler

Interface
REQ-001 SHALL have parameter NUM_IF, default 8, meaning the number of sensor interfaces served (1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, meaning the maximum wait for an interface done (2 s at 50 MHz).
REQ-003 SHALL have port i_Clock, input, 1, the single 50 MHz system clock; all state updates on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port i_cmd_valid, input, 1, a command is present on i_cmd_addr/i_cmd_req.
REQ-006 SHALL have port i_cmd_addr, input, 8, the target interface index.
REQ-007 SHALL have port i_cmd_req, input, 8, the request code: 0x01 status, 0x02 temperature, 0x03 humidity.
REQ-008 SHALL have port o_cmd_ready, output, 1, the scheduler accepts a command this cycle.
REQ-009 SHALL have port o_if_en, output, NUM_IF, one-hot enable pulse to the selected interface.
REQ-010 SHALL have port o_if_request, output, 8, the request byte shared by all interfaces.
REQ-011 SHALL have port i_if_data, input, 8*NUM_IF, data bytes; interface k occupies bits [8k+7:8k].
REQ-012 SHALL have port i_if_done, input, NUM_IF, per-interface one-cycle done pulses.
REQ-013 SHALL have port o_rsp_valid, output, 1, a response is available.
REQ-014 SHALL have port o_rsp_status, output, 8, the response status code.
REQ-015 SHALL have port o_rsp_data, output, 8, the response data byte.
REQ-016 SHALL have port i_rsp_ready, input, 1, the consumer accepts the response.
REQ-017 SHALL have port o_busy, output, 1, high in every state other than IDLE.

Function
REQ-018 SHALL implement the states IDLE, DECODE, ENABLE, WAIT and RESPOND.
REQ-019 o_cmd_ready SHALL be 1 only in IDLE; command accepted when i_cmd_valid&o_cmd_ready; addr/req latched; next state DECODE.
REQ-020 DECODE SHALL go to RESPOND with status 0xE1, data 0x00 when addr >= NUM_IF; address check takes priority over request check.
REQ-021 DECODE SHALL go to RESPOND with status 0xE2, data 0x00 when req is not 0x01/0x02/0x03; otherwise it SHALL go to ENABLE.
REQ-022 ENABLE SHALL assert o_if_en[addr] for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-023 o_if_request SHALL equal the latched req from DECODE until leaving WAIT, and SHALL be 0x00 otherwise.
REQ-024 WAIT SHALL count cycles; on i_if_done[addr]=1 it SHALL capture i_if_data[addr] into o_rsp_data and go to RESPOND.
REQ-025 Captured data 0x80 SHALL set status 0xE4 (sensor error); any other captured value SHALL set status 0x00.
REQ-026 Done pulses from non-selected interfaces SHALL be ignored in every state, as SHALL done pulses in any state other than WAIT.
REQ-027 After TIMEOUT_CYCLES cycles in WAIT without done, the block SHALL go to RESPOND with status 0xE3, data 0x00; done and timeout in the same cycle SHALL resolve as done.
REQ-028 RESPOND SHALL hold o_rsp_valid=1 with stable status/data until i_rsp_ready=1, then go to IDLE on the next edge.
REQ-029 Command-accept to o_rsp_valid latency SHALL be 2 cycles for invalid commands, and 3 cycles plus the wait time (done-pulse wait or timeout) for valid commands.
REQ-030 The timeout counter SHALL be 32 bits and SHALL saturate rather than wrap.
REQ-031 i_cmd_valid while busy SHALL not be accepted; commands SHALL be served strictly one at a time, in arrival order.

Reset
REQ-032 i_Rst=1 SHALL immediately force state IDLE, o_if_en=0, o_if_request=0x00, o_rsp_valid=0, o_rsp_status=0x00, o_rsp_data=0x00, o_busy=0, and counter=0.
REQ-033 Reset asserted mid-WAIT SHALL abort the transaction with no response; a later done pulse SHALL be ignored.

Verification
REQ-034 addr=2, req=0x02, i_if_done[2] pulses 10 cycles after the enable with data 0x19 -> exactly one o_if_en[2] pulse, o_if_request=0x02 during WAIT, response 0x00/0x19.
REQ-035 addr=9 with NUM_IF=8 -> status 0xE1, data 0x00, valid 2 cycles after accept, no enable pulse; req=0x07 -> status 0xE2.
REQ-036 TIMEOUT_CYCLES=50, no done -> status 0xE3 after 50 WAIT cycles; a late done pulse is then ignored.
REQ-037 Data 0x80 on req=0x01 -> status 0xE4, data 0x80; i_rsp_ready held low 20 cycles -> response stable, o_cmd_ready=0.
REQ-038 i_if_done[3] pulses while addr=1 is selected -> ignored; reset pulse in WAIT -> all outputs return to reset values.
